// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load alignment/extension, result select,
// register-file write port, forwarding copy, load-fault detection and retire counter.
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_valid,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_rd,
    input  logic [1:0]           mem_result_sel,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_load_data,
    input  logic [2:0]           mem_funct3,
    input  logic [XLEN-1:0]      mem_pc_plus4,
    input  logic                 wb_stall,
    input  logic                 wb_flush,
    output logic                 reg_write_enable,
    output logic [4:0]           write_reg,
    output logic [XLEN-1:0]      write_back_data,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 load_fault,
    output logic [CNT_WIDTH-1:0] retire_count
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic                 valid_r;
    logic                 reg_write_r;
    logic [4:0]           rd_r;
    logic [1:0]           result_sel_r;
    logic [XLEN-1:0]      alu_result_r;
    logic [XLEN-1:0]      load_data_r;
    logic [2:0]           funct3_r;
    logic [XLEN-1:0]      pc_plus4_r;
    logic [CNT_WIDTH-1:0] retire_count_r;

    logic [XLEN-1:0]      load_value_s;
    logic [XLEN-1:0]      result_s;
    logic                 load_fault_s;
    logic                 fwd_ok_s;

    function automatic logic [XLEN-1:0] extract_load(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extract_load = {{(XLEN-8){b[7]}}, b};
            3'b001:  extract_load = {{(XLEN-16){h[15]}}, h};
            3'b010:  extract_load = word;
            3'b100:  extract_load = {{(XLEN-8){1'b0}}, b};
            3'b101:  extract_load = {{(XLEN-16){1'b0}}, h};
            default: extract_load = '0;
        endcase
    endfunction

    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
        logic misaligned;
        logic illegal;
        misaligned = (((f3 == 3'b001) || (f3 == 3'b101)) && off[0]) ||
                     ((f3 == 3'b010) && (off != 2'b00));
        illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        load_bad   = misaligned || illegal;
    endfunction

    // MEM/WB pipeline register: flush beats stall, stall holds, otherwise capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= 1'b0;
            reg_write_r  <= 1'b0;
            rd_r         <= 5'd0;
            result_sel_r <= 2'b00;
            alu_result_r <= '0;
            load_data_r  <= '0;
            funct3_r     <= 3'b000;
            pc_plus4_r   <= '0;
        end else if (wb_flush) begin
            valid_r <= 1'b0;
        end else if (!wb_stall) begin
            valid_r      <= mem_valid;
            reg_write_r  <= mem_reg_write;
            rd_r         <= mem_rd;
            result_sel_r <= mem_result_sel;
            alu_result_r <= mem_alu_result;
            load_data_r  <= mem_load_data;
            funct3_r     <= mem_funct3;
            pc_plus4_r   <= mem_pc_plus4;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Retire counter: the WB occupant completes on any unstalled edge, faulting or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count_r <= '0;
        end else if (valid_r && !wb_stall) begin
            retire_count_r <= retire_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            retire_count_r <= retire_count_r;
        end
    end

    // Result selection and write-port qualification from registered WB state only
    always_comb begin
        load_value_s = extract_load(funct3_r, alu_result_r[1:0], load_data_r);
        load_fault_s = valid_r && (result_sel_r == SEL_LOAD) && load_bad(funct3_r, alu_result_r[1:0]);
        case (result_sel_r)
            SEL_ALU:  result_s = alu_result_r;
            SEL_LOAD: result_s = load_value_s;
            SEL_PC4:  result_s = pc_plus4_r;
            default:  result_s = alu_result_r;
        endcase
        fwd_ok_s = valid_r && reg_write_r && (rd_r != 5'd0) && !load_fault_s;
    end

    // Write port and forwarding copy; stall only blocks the commit, not the forward
    always_comb begin
        reg_write_enable = fwd_ok_s && !wb_stall;
        write_reg        = rd_r;
        write_back_data  = result_s;
        fwd_valid        = fwd_ok_s;
        fwd_rd           = rd_r;
        fwd_data         = result_s;
        load_fault       = load_fault_s;
        retire_count     = retire_count_r;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven bench for wb_stage (8-bit retire counter so wrap is reachable).
module tb_wb_stage;

    localparam int XLEN = 32;
    localparam int CW   = 8;

    logic            clk;
    logic            rst_n;
    logic            mem_valid;
    logic            mem_reg_write;
    logic [4:0]      mem_rd;
    logic [1:0]      mem_result_sel;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_load_data;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_pc_plus4;
    logic            wb_stall;
    logic            wb_flush;
    logic            reg_write_enable;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_back_data;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            load_fault;
    logic [CW-1:0]   retire_count;

    wb_stage #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_result_sel(mem_result_sel), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_funct3(mem_funct3), .mem_pc_plus4(mem_pc_plus4),
        .wb_stall(wb_stall), .wb_flush(wb_flush),
        .reg_write_enable(reg_write_enable), .write_reg(write_reg),
        .write_back_data(write_back_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .load_fault(load_fault), .retire_count(retire_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string           name;
        logic            valid;
        logic            reg_write;
        logic [4:0]      rd;
        logic [1:0]      sel;
        logic [31:0]     alu;
        logic [31:0]     ld;
        logic [2:0]      f3;
        logic [31:0]     pc4;
        logic            exp_we;
        logic            exp_fault;
        logic            chk_data;
        logic [31:0]     exp_data;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [CW-1:0] exp_cnt;
    logic          slot_valid;
    int            x1_writes;
    vec_t          vecs[$];

    localparam logic [31:0] W = 32'h80FF_7F01;

    always @(posedge clk) begin
        if (reg_write_enable && write_reg == 5'd1) x1_writes <= x1_writes + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] f3,
                         input logic [31:0] pc4);
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_result_sel = sel;
        mem_alu_result = alu; mem_load_data = ld; mem_funct3 = f3; mem_pc_plus4 = pc4;
    endtask

    // one unstalled, unflushed edge with retire model update
    task automatic tick_plain(input logic new_valid);
        @(posedge clk);
        if (slot_valid) exp_cnt = exp_cnt + 8'd1;
        slot_valid = new_valid;
        #1;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v.valid, v.reg_write, v.rd, v.sel, v.alu, v.ld, v.f3, v.pc4);
        tick_plain(v.valid);
        chk({v.name, " we"},    {63'd0, reg_write_enable}, {63'd0, v.exp_we});
        chk({v.name, " fwdv"},  {63'd0, fwd_valid},        {63'd0, v.exp_we});
        chk({v.name, " fault"}, {63'd0, load_fault},       {63'd0, v.exp_fault});
        chk({v.name, " wreg"},  {59'd0, write_reg},        {59'd0, v.rd});
        if (v.chk_data) begin
            chk({v.name, " data"},  {32'd0, write_back_data}, {32'd0, v.exp_data});
            chk({v.name, " fdata"}, {32'd0, fwd_data},        {32'd0, v.exp_data});
        end
        chk({v.name, " retire"}, {56'd0, retire_count}, {56'd0, exp_cnt});
    endtask

    function automatic vec_t mk(input string nm, input logic v, input logic rw, input logic [4:0] rd,
                                input logic [1:0] sel, input logic [31:0] alu, input logic [2:0] f3,
                                input logic [31:0] pc4, input logic we, input logic flt,
                                input logic cd, input logic [31:0] d);
        vec_t r;
        r.name = nm; r.valid = v; r.reg_write = rw; r.rd = rd; r.sel = sel; r.alu = alu;
        r.ld = W; r.f3 = f3; r.pc4 = pc4; r.exp_we = we; r.exp_fault = flt;
        r.chk_data = cd; r.exp_data = d;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0; x1_writes = 0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 3'b000, 32'd0);
        exp_cnt = 8'd0; slot_valid = 1'b0;

        vecs.push_back(mk("alu_x5",   1, 1, 5'd5, 2'b00, 32'h0000_1234, 3'b000, 32'd0, 1, 0, 1, 32'h0000_1234));
        vecs.push_back(mk("alu_x0",   1, 1, 5'd0, 2'b00, 32'h0000_1234, 3'b000, 32'd0, 0, 0, 1, 32'h0000_1234));
        vecs.push_back(mk("lb_off0",  1, 1, 5'd6, 2'b01, 32'h0000_1000, 3'b000, 32'd0, 1, 0, 1, 32'h0000_0001));
        vecs.push_back(mk("lb_off3",  1, 1, 5'd6, 2'b01, 32'h0000_1003, 3'b000, 32'd0, 1, 0, 1, 32'hFFFF_FF80));
        vecs.push_back(mk("lb_off1",  1, 1, 5'd6, 2'b01, 32'h0000_1001, 3'b000, 32'd0, 1, 0, 1, 32'h0000_007F));
        vecs.push_back(mk("lbu_off2", 1, 1, 5'd7, 2'b01, 32'h0000_1002, 3'b100, 32'd0, 1, 0, 1, 32'h0000_00FF));
        vecs.push_back(mk("lh_off2",  1, 1, 5'd8, 2'b01, 32'h0000_1002, 3'b001, 32'd0, 1, 0, 1, 32'hFFFF_80FF));
        vecs.push_back(mk("lhu_off0", 1, 1, 5'd8, 2'b01, 32'h0000_1000, 3'b101, 32'd0, 1, 0, 1, 32'h0000_7F01));
        vecs.push_back(mk("lhu_off2", 1, 1, 5'd8, 2'b01, 32'h0000_1002, 3'b101, 32'd0, 1, 0, 1, 32'h0000_80FF));
        vecs.push_back(mk("lw_off0",  1, 1, 5'd9, 2'b01, 32'h0000_1000, 3'b010, 32'd0, 1, 0, 1, 32'h80FF_7F01));
        vecs.push_back(mk("lw_mis",   1, 1, 5'd9, 2'b01, 32'h0000_1002, 3'b010, 32'd0, 0, 1, 0, 32'd0));
        vecs.push_back(mk("lh_mis",   1, 1, 5'd9, 2'b01, 32'h0000_1001, 3'b001, 32'd0, 0, 1, 0, 32'd0));
        vecs.push_back(mk("f3_011",   1, 1, 5'd9, 2'b01, 32'h0000_1000, 3'b011, 32'd0, 0, 1, 0, 32'd0));
        vecs.push_back(mk("alu_fauxld", 1, 1, 5'd9, 2'b00, 32'h0000_1002, 3'b010, 32'd0, 1, 0, 1, 32'h0000_1002));
        vecs.push_back(mk("pc4_x1",   1, 1, 5'd1, 2'b10, 32'h0000_5555, 3'b000, 32'h0000_0104, 1, 0, 1, 32'h0000_0104));
        vecs.push_back(mk("resv_sel", 1, 1, 5'd3, 2'b11, 32'h0000_ABCD, 3'b000, 32'h0000_0200, 1, 0, 1, 32'h0000_ABCD));
        vecs.push_back(mk("no_rw",    1, 0, 5'd4, 2'b00, 32'h0000_0042, 3'b000, 32'd0, 0, 0, 1, 32'h0000_0042));
        vecs.push_back(mk("invalid",  0, 1, 5'd4, 2'b00, 32'h0000_0043, 3'b000, 32'd0, 0, 0, 1, 32'h0000_0043));
        vecs.push_back(mk("alu_x31",  1, 1, 5'd31, 2'b00, 32'hDEAD_BEEF, 3'b000, 32'd0, 1, 0, 1, 32'hDEAD_BEEF));

        // reset state
        #12;
        chk("rst we",    {63'd0, reg_write_enable}, 64'd0);
        chk("rst fwdv",  {63'd0, fwd_valid},        64'd0);
        chk("rst fault", {63'd0, load_fault},       64'd0);
        chk("rst data",  {32'd0, write_back_data},  64'd0);
        chk("rst wreg",  {59'd0, write_reg},        64'd0);
        chk("rst cnt",   {56'd0, retire_count},     64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // asynchronous reset with an instruction in flight
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd10, 2'b00, 32'h0000_0999, W, 3'b000, 32'd0);
        tick_plain(1'b1);
        chk("pre_rst we", {63'd0, reg_write_enable}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst we",   {63'd0, reg_write_enable}, 64'd0);
        chk("midrst fwdv", {63'd0, fwd_valid},        64'd0);
        chk("midrst data", {32'd0, fwd_data},         64'd0);
        chk("midrst frd",  {59'd0, fwd_rd},           64'd0);
        chk("midrst cnt",  {56'd0, retire_count},     64'd0);
        exp_cnt = 8'd0; slot_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 2'b00, 32'h0000_0777, W, 3'b000, 32'd0);
        tick_plain(1'b1);
        chk("postrst we",   {63'd0, reg_write_enable}, 64'd1);
        chk("postrst data", {32'd0, write_back_data},  64'h777);
        chk("postrst cnt",  {56'd0, retire_count},     64'd0);

        // JAL held by stall for 3 edges
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd1, 2'b10, 32'h0000_0010, W, 3'b000, 32'h0000_0104);
        tick_plain(1'b1);
        x1_writes = 0;
        wb_stall = 1'b1;
        drive(1'b1, 1'b1, 5'd2, 2'b00, 32'h0000_0055, W, 3'b000, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall we",    {63'd0, reg_write_enable}, 64'd0);
            chk("stall fwdv",  {63'd0, fwd_valid},        64'd1);
            chk("stall fdata", {32'd0, fwd_data},         64'h104);
            chk("stall frd",   {59'd0, fwd_rd},           64'd1);
            chk("stall cnt",   {56'd0, retire_count},     {56'd0, exp_cnt});
        end
        @(negedge clk);
        wb_stall = 1'b0;
        #1;
        chk("unstall we", {63'd0, reg_write_enable}, 64'd1);
        tick_plain(1'b1);
        chk("jal cnt",    {56'd0, retire_count}, {56'd0, exp_cnt});
        chk("next wreg",  {59'd0, write_reg},    64'd2);
        chk("next data",  {32'd0, write_back_data}, 64'h55);
        chk("x1 writes",  x1_writes, 64'd1);

        // flush and stall together
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd3, 2'b00, 32'h0000_0077, W, 3'b000, 32'd0);
        tick_plain(1'b1);
        wb_stall = 1'b1; wb_flush = 1'b1;
        @(posedge clk); #1;
        slot_valid = 1'b0;
        wb_stall = 1'b0; wb_flush = 1'b0;
        #1;
        chk("fs we",   {63'd0, reg_write_enable}, 64'd0);
        chk("fs fwdv", {63'd0, fwd_valid},        64'd0);
        chk("fs cnt",  {56'd0, retire_count},     {56'd0, exp_cnt});
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, W, 3'b000, 32'd0);
        tick_plain(1'b0);
        chk("fs cnt2", {56'd0, retire_count}, {56'd0, exp_cnt});

        // counter wrap
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 2'b00, 32'd0, W, 3'b000, 32'd0);
        for (int k = 0; k < 300 && exp_cnt != 8'hFF; k++) tick_plain(1'b1);
        chk("cnt ff", {56'd0, retire_count}, 64'hFF);
        tick_plain(1'b1);
        chk("cnt wrap", {56'd0, retire_count}, 64'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage RISC-V pipeline. It holds the MEM/WB pipeline register and selects the result: ALU result, aligned and extended load data, or PC+4. It drives the write port of the register file (enable, address, data) and gives the same value to the forwarding unit. It also keeps the retired-instruction counter and flags misaligned or illegal loads so they never reach the register file.

## Interface
- XLEN, 32, datapath and register width
- CNT_WIDTH, 64, width of retired-instruction counter
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mem_valid  input  1  MEM stage presents a valid instruction
- mem_reg_write  input  1  instruction writes rd
- mem_rd  input  5  destination register address
- mem_result_sel  input  2  00 ALU, 01 LOAD, 10 PC+4, 11 reserved (treated as ALU)
- mem_alu_result  input  XLEN  ALU result; for loads, the effective address
- mem_load_data  input  XLEN  raw aligned word from data memory
- mem_funct3  input  3  load size/sign code
- mem_pc_plus4  input  XLEN  link value for JAL/JALR
- wb_stall  input  1  hold WB slot; no capture, no retire, no write
- wb_flush  input  1  invalidate WB slot at next edge
- reg_write_enable  output  1  register-file write enable
- write_reg  output  5  register-file write address
- write_back_data  output  XLEN  register-file write data
- fwd_valid / fwd_rd / fwd_data  output  1/5/XLEN  forwarding copy of the write port
- load_fault  output  1  WB slot holds a misaligned or illegal load
- retire_count  output  CNT_WIDTH  instructions retired since reset

## Operation
- **Pipeline register.** It holds: valid, reg_write, rd, result_sel, alu_result, load_data, funct3, pc_plus4.
- **Capture priority:**
  - wb_flush=1: valid<=0. Flush wins over stall.
  - Otherwise wb_stall=1: hold all fields.
  - Otherwise: load all fields from mem_*, with valid<=mem_valid.
- **Load extraction.** Works on registered data. The byte offset is alu_result[1:0].
  - 000 LB: sign-extend byte[offset].
  - 001 LH: sign-extend half[offset[1]].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte[offset].
  - 101 LHU: zero-extend half[offset[1]].
- **Load faults.** A load is misaligned for LH/LHU with offset[0]=1, or LW with offset!=0. funct3 011/110/111 is illegal.
  - load_fault = valid & result_sel==LOAD & (misaligned | illegal).
- **Result select.** ALU or reserved selects alu_result; LOAD selects the extracted value; PC+4 selects pc_plus4.
- **Write port.**
  - write_reg = rd.
  - write_back_data = selected result.
  - reg_write_enable = valid & reg_write & (rd!=0) & ~load_fault & ~wb_stall.
  - Writes to x0 are always suppressed.
- **Forwarding.** fwd_valid = valid & reg_write & (rd!=0) & ~load_fault. It ignores stall, so the held value is still forwarded. fwd_rd and fwd_data equal write_reg and write_back_data.
- **Retire.** retire_count increments by 1 on every edge where valid=1 and wb_stall=0. Faulting loads and instructions with reg_write=0 also retire. The counter wraps from all-ones to 0. Flush and stall on the same edge: the instruction is dropped and does not retire.

## Timing
- **Reset (rst_n low, asynchronous).** valid=0 and retire_count=0. All outputs read 0: reg_write_enable, fwd_valid, load_fault, write_reg, write_back_data, fwd_rd, fwd_data. Stored data fields clear to 0.
- **Reset mid-operation.** The in-flight WB instruction is discarded with no write and no retire.
- **Deassertion.** The first capture happens at the first rising edge with rst_n high.
- **Latency.** An instruction captured at edge N shows on the write port combinationally after N. The register file commits it at edge N+1, and retire_count reflects it after N+1.
- **Throughput.** One instruction per cycle, with no bubbles added.
- **Output timing.** All outputs depend only on WB register state plus wb_stall, never on mem_* inputs; the block adds no combinational path from mem_*.

## Test plan
- **Reset.** Assert rst_n=0 mid-stream with valid instructions in flight -> all outputs are 0 immediately (asynchronous) and retire_count=0. After release, the first instruction writes at the expected edge.
- **ALU and x0.** ADD result 0x0000_1234 to rd=5, then same with rd=0 -> write x5=0x00001234, then no write for rd=0. retire_count advances by 2.
- **Load extraction.** Word 0x80FF_7F01 with each funct3/offset:
  - LB off0 -> 0x00000001; LB off3 -> 0xFFFFFF80; LBU off2 -> 0x000000FF.
  - LH off2 -> 0xFFFF80FF; LHU off0 -> 0x00007F01; LW off0 -> 0x80FF7F01.
- **Faults.** LW at address 0x...02, LH at 0x...01, funct3=011 -> load_fault=1 on each, reg_write_enable=0, fwd_valid=0, retire_count still increments.
- **Stall, flush, link.**
  - JAL with pc_plus4=0x0000_0104, rd=1, held 3 cycles by wb_stall -> fwd_valid stays 1 with data 0x104. Exactly one write x1=0x104 after the stall drops, and retire +1.
  - wb_flush and wb_stall asserted together -> the slot is invalidated, with no write and no retire.
- **Counter wrap.** Force retire_count to all-ones (CNT_WIDTH=8 build: 0xFF), retire one instruction -> retire_count=0x00.
